countdown_timer: RTL

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/clock_pkg.sv | 42 ++++
 rtl/countdown_timer_hms_decrement.sv | 38 +++
 rtl/countdown_timer.sv | 116 +++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared time-of-day constants, field widths and the countdown FSM state type.
// Also used by the clock24 and stopwatch stages.
package clock_pkg;

    localparam int HOURS_W = 5;
    localparam int MINS_W  = 6;
    localparam int SECS_W  = 6;

    localparam logic [SECS_W-1:0]  SECS_MAX  = 6'd59;
    localparam logic [MINS_W-1:0]  MINS_MAX  = 6'd59;
    localparam logic [HOURS_W-1:0] HOURS_MAX = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } timer_state_e;

    function automatic logic [HOURS_W-1:0] clamp_hours(input logic [HOURS_W-1:0] value,
                                                       input logic [HOURS_W-1:0] limit);
        logic [HOURS_W-1:0] result;
        if (value > limit) begin
            result = limit;
        end else begin
            result = value;
        end
        return result;
    endfunction

    // Minutes and seconds share the same 0..59 range and width.
    function automatic logic [SECS_W-1:0] clamp_min_sec(input logic [SECS_W-1:0] value);
        logic [SECS_W-1:0] result;
        if (value > SECS_MAX) begin
            result = SECS_MAX;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/countdown_timer_hms_decrement.sv
// One-second borrow-chain decrement of an hh:mm:ss value, saturating at zero,
// with a flag telling whether the decremented value is 00:00:00.
module hms_decrement
    import clock_pkg::*;
(
    input  logic [HOURS_W-1:0] cur_hours,
    input  logic [MINS_W-1:0]  cur_mins,
    input  logic [SECS_W-1:0]  cur_secs,
    output logic [HOURS_W-1:0] dec_hours,
    output logic [MINS_W-1:0]  dec_mins,
    output logic [SECS_W-1:0]  dec_secs,
    output logic               dec_zero
);

    // Borrow chain: seconds, then minutes, then hours; zero stays zero.
    always_comb begin
        dec_hours = cur_hours;
        dec_mins  = cur_mins;
        dec_secs  = cur_secs;
        if (cur_secs != 6'd0) begin
            dec_secs = cur_secs - 6'd1;
        end else if (cur_mins != 6'd0) begin
            dec_mins = cur_mins - 6'd1;
            dec_secs = SECS_MAX;
        end else if (cur_hours != 5'd0) begin
            dec_hours = cur_hours - 5'd1;
            dec_mins  = MINS_MAX;
            dec_secs  = SECS_MAX;
        end else begin
            dec_hours = 5'd0;
            dec_mins  = 6'd0;
            dec_secs  = 6'd0;
        end
    end

    assign dec_zero = (dec_hours == 5'd0) && (dec_mins == 6'd0) && (dec_secs == 6'd0);

endmodule

// File: rtl/countdown_timer.sv
// Presettable hh:mm:ss countdown timer with start/pause control and an expiry flag.
// Outputs drive the mode-3 input of the display mux directly.
module countdown_timer
    import clock_pkg::*;
#(
    parameter int unsigned MAX_HOURS = 23
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               load,
    input  logic               start,
    input  logic               pause,
    input  logic [HOURS_W-1:0] hours_i,
    input  logic [MINS_W-1:0]  mins_i,
    input  logic [SECS_W-1:0]  secs_i,
    output logic [HOURS_W-1:0] hours,
    output logic [MINS_W-1:0]  mins,
    output logic [SECS_W-1:0]  secs,
    output logic               running,
    output logic               done
);

    localparam logic [HOURS_W-1:0] HOURS_LIMIT = HOURS_W'(MAX_HOURS);

    timer_state_e       state_r;
    timer_state_e       state_s;
    logic [HOURS_W-1:0] hours_r;
    logic [MINS_W-1:0]  mins_r;
    logic [SECS_W-1:0]  secs_r;
    logic [HOURS_W-1:0] hours_s;
    logic [MINS_W-1:0]  mins_s;
    logic [SECS_W-1:0]  secs_s;
    logic [HOURS_W-1:0] dec_hours_s;
    logic [MINS_W-1:0]  dec_mins_s;
    logic [SECS_W-1:0]  dec_secs_s;
    logic               dec_zero_s;
    logic               count_zero_s;

    hms_decrement u_dec (
        .cur_hours (hours_r),
        .cur_mins  (mins_r),
        .cur_secs  (secs_r),
        .dec_hours (dec_hours_s),
        .dec_mins  (dec_mins_s),
        .dec_secs  (dec_secs_s),
        .dec_zero  (dec_zero_s)
    );

    assign count_zero_s = (hours_r == 5'd0) && (mins_r == 6'd0) && (secs_r == 6'd0);

    // Next state and count; events are prioritised load > start > pause > tick.
    always_comb begin
        state_s = state_r;
        hours_s = hours_r;
        mins_s  = mins_r;
        secs_s  = secs_r;
        if (load) begin
            state_s = ST_IDLE;
            hours_s = clamp_hours(hours_i, HOURS_LIMIT);
            mins_s  = clamp_min_sec(mins_i);
            secs_s  = clamp_min_sec(secs_i);
        end else if (start) begin
            case (state_r)
                ST_IDLE, ST_PAUSED: begin
                    if (!count_zero_s) begin
                        state_s = ST_RUNNING;
                    end else begin
                        state_s = state_r;
                    end
                end
                default: state_s = state_r;
            endcase
        end else if (pause) begin
            if (state_r == ST_RUNNING) begin
                state_s = ST_PAUSED;
            end else begin
                state_s = state_r;
            end
        end else if (tick && (state_r == ST_RUNNING)) begin
            hours_s = dec_hours_s;
            mins_s  = dec_mins_s;
            secs_s  = dec_secs_s;
            // Expiry is entered on the same edge that the zero count appears.
            if (dec_zero_s) begin
                state_s = ST_EXPIRED;
            end else begin
                state_s = ST_RUNNING;
            end
        end else begin
            state_s = state_r;
        end
    end

    // State and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            hours_r <= 5'd0;
            mins_r  <= 6'd0;
            secs_r  <= 6'd0;
        end else begin
            state_r <= state_s;
            hours_r <= hours_s;
            mins_r  <= mins_s;
            secs_r  <= secs_s;
        end
    end

    assign hours   = hours_r;
    assign mins    = mins_r;
    assign secs    = secs_r;
    assign running = (state_r == ST_RUNNING);
    assign done    = (state_r == ST_EXPIRED);

endmodule
